// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: extracts and extends the immediate field of a 32-bit instruction
// and queues the {imm, err} result in a small valid/ready output FIFO. The
// outputs come from a dedicated head register, so instr never reaches imm_ext
// combinationally.
module imm_gen_pipe #(
    parameter int XLEN        = 32,   // 32 or 64
    parameter int AUTO_DECODE = 0,    // 1: derive the format from the opcode
    parameter int DEPTH       = 2     // 1..4 output entries
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [2:0]      imm_src,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] imm_ext,
    output logic            fmt_err
);

    typedef enum logic [2:0] {
        FMT_I   = 3'b000,
        FMT_S   = 3'b001,
        FMT_B   = 3'b010,
        FMT_U   = 3'b011,
        FMT_J   = 3'b100,
        FMT_Z   = 3'b101,
        FMT_BAD = 3'b111
    } fmt_e;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic            err;
    } entry_t;

    localparam logic [2:0] DEPTH_C = 3'(DEPTH);
    localparam logic [1:0] LAST_C  = 2'(DEPTH - 1);

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == LAST_C) ? 2'd0 : p + 2'd1;
    endfunction

    fmt_e        auto_fmt;
    fmt_e        fmt;
    logic [31:0] imm32;
    entry_t      new_entry;

    logic [2:0]  count_q, count_d;
    logic [1:0]  head_q, head_d;
    logic [1:0]  tail_q, tail_d;
    entry_t      mem [4];
    entry_t      head_next;
    logic        push, pop;

    // Opcode to format map used when the format is auto-decoded.
    always_comb begin
        auto_fmt = FMT_BAD;
        case (instr[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: auto_fmt = FMT_I;
            7'b0100011:                         auto_fmt = FMT_S;
            7'b1100011:                         auto_fmt = FMT_B;
            7'b0110111, 7'b0010111:             auto_fmt = FMT_U;
            7'b1101111:                         auto_fmt = FMT_J;
            7'b1110011:                         auto_fmt = FMT_Z;
            default:                            auto_fmt = FMT_BAD;
        endcase
    end

    assign fmt = (AUTO_DECODE != 0) ? auto_fmt : fmt_e'(imm_src);

    // Build the 32-bit immediate; every format except Z has bit 31 = instr[31],
    // so a signed widening gives the required extension to XLEN.
    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        imm32         = '0;
        new_entry.err = 1'b0;
        case (fmt)
            FMT_I: imm32 = {{20{instr[31]}}, instr[31:20]};
            FMT_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U: imm32 = {instr[31:12], 12'b0};
            FMT_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            FMT_Z: imm32 = {27'b0, instr[19:15]};
            default: begin
                imm32         = '0;
                new_entry.err = 1'b1;
            end
        endcase
        new_entry.imm = XLEN'($signed(imm32));
    end

    assign in_ready  = (count_q != DEPTH_C);
    assign out_valid = (count_q != 3'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Next pointers/count and the entry that will sit at the head after this edge.
    always_comb begin
        head_d  = pop  ? ptr_inc(head_q) : head_q;
        tail_d  = push ? ptr_inc(tail_q) : tail_q;
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
        if (count_d == 3'd0) begin
            head_next.imm = imm_ext;
            head_next.err = 1'b0;
        end else if (push && (head_d == tail_q)) begin
            head_next = new_entry;
        end else begin
            head_next = mem[head_d];
        end
    end

    // Control state and the registered head outputs.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 3'd0;
            head_q  <= 2'd0;
            tail_q  <= 2'd0;
            imm_ext <= '0;
            fmt_err <= 1'b0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            imm_ext <= head_next.imm;
            fmt_err <= head_next.err;
        end
    end

    // Entry storage written at the tail on a push.
    // NOTE: storage is not reset; count gates every read, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem[tail_q] <= new_entry;
        end
    end

endmodule
